seq_101_frame_counter: RTL and testbench
========================================

# seq_101_frame_counter

Serial-stream controller for the "101" pattern-count datapath. It accepts one bit per handshake, MSB first, and sequences framing: a frame is FRAME_LEN bits. For each frame it runs an overlap or non-overlap 101 detector and returns the per-frame match count through a valid/ready result port. It sits between a serial bit source and whichever consumer used the parallel 32-bit counter, and returns the same counts for the same 32-bit word.

## Interface
- FRAME_LEN, 32, bits per frame; legal range is 3 or more.
- CNT_W, 6, width of the count; must satisfy 2^CNT_W > FRAME_LEN-2.
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  in_bit is valid.
- in_bit  input  1  serial data, MSB of frame first.
- in_ready  output  1  block accepts in_bit this cycle.
- overlap  input  1  mode; 1 = overlapping matches, 0 = non-overlapping; sampled on first bit of each frame.
- flush  input  1  synchronous discard of the partial frame.
- cnt_valid  output  1  result register holds an undelivered count.
- cnt_data  output  CNT_W  match count of the completed frame.
- cnt_ready  input  1  consumer takes result.
- busy  output  1  a frame is partially received (bit counter ≠ 0).

## Operation
- Accept event: in_valid && in_ready at rising clk.
- Frame FSM:
  - IDLE: bit counter = 0.
  - First accept → RUN; the same edge latches overlap into mode_q.
  - Accepting bit number FRAME_LEN → frame done, return to IDLE.
- Detector FSM, advanced only on accepts:
  - S0 → S1 on 1; stays S0 on 0.
  - S1 → S10 on 0; stays S1 on 1.
  - S10 on 1 → match. Next state is S1 if mode_q = 1, S0 if mode_q = 0.
  - S10 on 0 → S0.
  - Non-overlap is greedy from the MSB.
- Count: running counter increments on each match, including a match on the last bit of the frame. It never wraps by construction (max FRAME_LEN-2).
- Frame done:
  - cnt_data ← final count and cnt_valid ← 1.
  - Running count, detector and bit counter clear on the same edge.
  - The next frame may start on the very next cycle.
- Result drain: cnt_valid && cnt_ready at an edge clears cnt_valid, unless a new result loads on the same edge; then cnt_valid stays 1 with the new data.
- in_ready = !flush && (not last bit of frame || !cnt_valid || cnt_ready). Only the final bit of a frame is ever stalled.
- flush:
  - Clears the bit counter, detector and running count, and returns to IDLE.
  - Any bit presented that cycle is not accepted (in_ready = 0).
  - The result register is untouched.
- overlap changes mid-frame are ignored until the next frame's first bit.
- Reset mid-operation: everything returns to reset values immediately. Partial frame and undelivered result are lost.

## Timing
- Reset values:
  - Frame FSM IDLE, detector S0, counters 0.
  - cnt_valid 0, cnt_data 0, busy 0.
  - in_ready 1 once rst deasserts; in_ready is combinational from state.
- Throughput: one bit per cycle, sustained across frame boundaries while results drain.
- Latency: cnt_valid rises one cycle after the edge that accepts bit FRAME_LEN.
- cnt_data stable while cnt_valid=1 && cnt_ready=0.
- busy goes high the cycle after the first accept. It goes low the cycle after the last accept or a flush.

## Configuration
- SEQ101_MATCH_PULSE_EN defined:
  - Adds output match_pulse (1 bit, reset 0).
  - High for exactly one cycle following each edge on which a match is counted.
  - Back-to-back matches give a pulse per match.
- SEQ101_MATCH_PULSE_EN undefined: port and logic absent; all other behaviour identical.

## Test plan
- Overlap=1, frame 32'hAAAAAAAA streamed with no gaps, cnt_ready=1 → cnt_data=15, cnt_valid high one cycle after the 32nd accept. Repeat with overlap=0 → 8.
- Frame 32'h00000005 → 1 in both modes. Frame 32'hFFFFFFFF → 0. Frame 32'h00000000 → 0.
- Two back-to-back frames (AAAAAAAA overlap, then 00000005) with cnt_ready=0:
  - in_ready drops only on the 2nd frame's 32nd bit.
  - Raising cnt_ready → first result 15 drained and in_ready rises in that same cycle; the second result 1 then appears.
- 10 random bits, then flush asserted together with in_valid → bit not accepted, busy=0 next cycle. Next frame AAAAAAAA overlap=1 → 15 (no contamination).
- overlap=1 at first bit, toggled to 0 at bit 5 of AAAAAAAA → 15. rst pulsed mid-frame → all outputs at reset values, and the next full frame counts correctly.
- With SEQ101_MATCH_PULSE_EN: AAAAAAAA overlap=1 → 15 single-cycle match_pulse assertions, and the pulse count equals cnt_data.

Source files
------------

// File: rtl/seq_101_frame_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_101_frame_counter_if
// Purpose  : Serial bit input and frame-count result handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_101_frame_counter_if #(
    parameter int CNT_W = 6
);
    logic             in_valid;
    logic             in_bit;
    logic             in_ready;
    logic             overlap;
    logic             flush;
    logic             cnt_valid;
    logic [CNT_W-1:0] cnt_data;
    logic             cnt_ready;
    logic             busy;

    modport master (
        output in_valid, in_bit, overlap, flush, cnt_ready,
        input  in_ready, cnt_valid, cnt_data, busy
    );

    modport slave (
        input  in_valid, in_bit, overlap, flush, cnt_ready,
        output in_ready, cnt_valid, cnt_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/seq_101_frame_counter.sv
`default_nettype none
// ============================================================================
// Module   : seq_101_frame_counter
// Purpose  : Counts "101" patterns (overlap or greedy non-overlap) per serial
//            frame of FRAME_LEN bits, MSB first. SEQ101_MATCH_PULSE_EN adds a
//            one-cycle match_pulse output per counted match.
// Revision : 1.0 - initial release
// ============================================================================
module seq_101_frame_counter #(
    parameter int FRAME_LEN = 32,
    parameter int CNT_W     = 6
) (
    input  wire logic clk,
    input  wire logic rst,
`ifdef SEQ101_MATCH_PULSE_EN
    output logic      match_pulse,
`endif
    seq_101_frame_counter_if.slave bus
);
    localparam int              c_BW   = $clog2(FRAME_LEN);
    localparam logic [c_BW-1:0] c_LAST = c_BW'(FRAME_LEN - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    localparam logic [1:0] c_S0  = 2'd0;
    localparam logic [1:0] c_S1  = 2'd1;
    localparam logic [1:0] c_S10 = 2'd2;

    logic [0:0]       r_frame_state;
    logic [0:0]       w_frame_next;
    logic [1:0]       r_det_state;
    logic [1:0]       w_det_next;
    logic [c_BW-1:0]  r_bit_cnt;
    logic [CNT_W-1:0] r_run_cnt;
    logic [CNT_W-1:0] w_run_next;
    logic             r_mode;
    logic             r_cnt_valid;
    logic [CNT_W-1:0] r_cnt_data;
    logic             w_busy;
    logic             w_last;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_done;
    logic             w_match;

    // ---------------- frame FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_state <= c_IDLE;
        end else begin
            r_frame_state <= w_frame_next;
        end
    end

    always_comb begin
        w_frame_next = r_frame_state;
        case (r_frame_state)
            c_IDLE:  if (w_accept) w_frame_next = c_RUN;
            c_RUN:   if (bus.flush || w_done) w_frame_next = c_IDLE;
            default: w_frame_next = c_IDLE;
        endcase
    end

    // Only the final bit of a frame can be held off by an undelivered result.
    always_comb begin
        w_busy     = (r_frame_state == c_RUN);
        w_last     = w_busy && (r_bit_cnt == c_LAST);
        w_in_ready = !bus.flush && (!w_last || !r_cnt_valid || bus.cnt_ready);
    end

    assign w_accept = bus.in_valid && w_in_ready;
    assign w_done   = w_accept && w_last;

    // ---------------- detector FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_det_state <= c_S0;
        end else begin
            r_det_state <= w_det_next;
        end
    end

    always_comb begin
        w_det_next = r_det_state;
        if (bus.flush || w_done) begin
            w_det_next = c_S0;
        end else if (w_accept) begin
            case (r_det_state)
                c_S0:    w_det_next = bus.in_bit ? c_S1 : c_S0;
                c_S1:    w_det_next = bus.in_bit ? c_S1 : c_S10;
                c_S10:   w_det_next = (bus.in_bit && r_mode) ? c_S1 : c_S0;
                default: w_det_next = c_S0;
            endcase
        end
    end

    always_comb begin
        w_match = w_accept && bus.in_bit && (r_det_state == c_S10);
    end

    // ---------------- datapath ----------------
    assign w_run_next = r_run_cnt + {{(CNT_W-1){1'b0}}, w_match};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt   <= '0;
            r_run_cnt   <= '0;
            r_mode      <= 1'b0;
            r_cnt_valid <= 1'b0;
            r_cnt_data  <= '0;
        end else begin
            if (bus.flush) begin
                r_bit_cnt <= '0;
                r_run_cnt <= '0;
            end else if (w_accept) begin
                r_bit_cnt <= w_last ? '0 : r_bit_cnt + c_BW'(1);
                r_run_cnt <= w_last ? '0 : w_run_next;
            end

            if (w_accept && (r_frame_state == c_IDLE)) begin
                r_mode <= bus.overlap;
            end

            // A fresh result wins over the drain on the same edge.
            if (w_done) begin
                r_cnt_valid <= 1'b1;
                r_cnt_data  <= w_run_next;
            end else if (r_cnt_valid && bus.cnt_ready) begin
                r_cnt_valid <= 1'b0;
            end
        end
    end

`ifdef SEQ101_MATCH_PULSE_EN
    logic r_match_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_match_pulse <= 1'b0;
        end else begin
            r_match_pulse <= w_match;
        end
    end

    assign match_pulse = r_match_pulse;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.cnt_valid = r_cnt_valid;
    assign bus.cnt_data  = r_cnt_data;
    assign bus.busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_seq_101_frame_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_101_frame_counter
// Purpose  : Scoreboard bench for seq_101_frame_counter (32-bit frames).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_101_frame_counter;
    localparam int FRAME_LEN = 32;
    localparam int CNT_W     = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_101_frame_counter_if #(.CNT_W(CNT_W)) bif ();

`ifdef SEQ101_MATCH_PULSE_EN
    logic match_pulse;
    int   pulse_cnt  = 0;
    int   pulse_rise = 0;
    logic pulse_prev = 1'b0;
`endif

    seq_101_frame_counter #(
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef SEQ101_MATCH_PULSE_EN
        .match_pulse (match_pulse),
`endif
        .bus         (bif.slave)
    );

    int vectors = 0;
    int errors  = 0;
    int exp_q[$];

    // Independent reference: scan the word MSB first for 1-0-1 windows.
    function automatic int model(input logic [31:0] w, input logic ov);
        int n = 0;
        int i = 0;
        while (i <= 29) begin
            if (w[31-i] && !w[30-i] && w[29-i]) begin
                n++;
                i += ov ? 1 : 3;
            end else begin
                i++;
            end
        end
        return n;
    endfunction

    // Result monitor: samples 1 ns before each rising edge.
    initial begin
        logic [CNT_W-1:0] e;
        forever begin
            @(negedge clk);
            #4;
`ifdef SEQ101_MATCH_PULSE_EN
            if (match_pulse === 1'b1) pulse_cnt++;
            if (match_pulse === 1'b1 && pulse_prev !== 1'b1) pulse_rise++;
            pulse_prev = match_pulse;
`endif
            if (bif.cnt_valid === 1'b1 && bif.cnt_ready === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got %0d, required no result", bif.cnt_data);
                end else begin
                    e = CNT_W'(exp_q.pop_front());
                    if (bif.cnt_data !== e) begin
                        errors++;
                        $display("FAIL result_data: got %0d, required %0d", bif.cnt_data, e);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic send_bit(input logic b, input logic ov, output int stalls);
        stalls = 0;
        @(negedge clk);
        bif.in_valid = 1'b1;
        bif.in_bit   = b;
        bif.overlap  = ov;
        bif.flush    = 1'b0;
        #4;
        while (bif.in_ready !== 1'b1) begin
            if (stalls == 200) begin
                vectors++;
                errors++;
                $display("FAIL in_ready_timeout: in_ready=%b, required 1 within 200 cycles", bif.in_ready);
                return;
            end
            stalls++;
            @(negedge clk);
            #4;
        end
        @(posedge clk);
    endtask

    task automatic send_frame(input logic [31:0] w, input logic ov, input int nbits,
                              input int toggle_at, input bit push, output int total_stalls);
        int   st;
        int   exp;
        logic cur_ov;
        exp          = model(w, ov);
        total_stalls = 0;
        cur_ov       = ov;
        if (push) exp_q.push_back(exp);
        for (int i = 0; i < nbits; i++) begin
            if (i == toggle_at) cur_ov = !ov;
            send_bit(w[31-i], cur_ov, st);
            total_stalls += st;
            if (i == 0) begin
                #1;
                vectors++;
                if (bif.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_after_first: got %b, required 1", bif.busy);
                end
            end
            if (i == FRAME_LEN - 1) begin
                #1;
                vectors++;
                if (bif.cnt_valid !== 1'b1 || bif.cnt_data !== CNT_W'(exp) || bif.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_done_latency: valid=%b data=%0d busy=%b, required valid=1 data=%0d busy=0",
                             bif.cnt_valid, bif.cnt_data, bif.busy, exp);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bif.in_valid = 1'b0;
        bif.flush    = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bif.in_valid  = 1'b0;
        bif.in_bit    = 1'b0;
        bif.overlap   = 1'b0;
        bif.flush     = 1'b0;
        bif.cnt_ready = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (bif.cnt_valid !== 1'b0 || bif.cnt_data !== '0 || bif.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b data=%0d busy=%b, required 0 0 0",
                     bif.cnt_valid, bif.cnt_data, bif.busy);
        end
        rst = 1'b0;
        #4;
        vectors++;
        if (bif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", bif.in_ready);
        end
    endtask

    task automatic test_patterns();
        logic [31:0] words[6] = '{32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000005,
                                  32'h00000005, 32'hFFFFFFFF, 32'h00000000};
        logic        modes[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int st;
        int all_st;
        @(negedge clk);
        bif.cnt_ready = 1'b1;
        all_st = 0;
        for (int k = 0; k < 6; k++) begin
            send_frame(words[k], modes[k], FRAME_LEN, -1, 1'b1, st);
            all_st += st;
        end
        vectors++;
        if (all_st != 0) begin
            errors++;
            $display("FAIL streaming_stalls: got %0d stall cycles, required 0", all_st);
        end
        idle(3);
    endtask

    task automatic test_back_to_back();
        int st;
        @(negedge clk);
        bif.cnt_ready = 1'b0;
        send_frame(32'hAAAAAAAA, 1'b1, FRAME_LEN, -1, 1'b1, st);
        send_frame(32'h00000005, 1'b1, FRAME_LEN - 1, -1, 1'b1, st);
        vectors++;
        if (st != 0) begin
            errors++;
            $display("FAIL b2b_early_stall: got %0d stalls, required 0", st);
        end
        @(negedge clk);
        bif.in_valid = 1'b1;
        bif.in_bit   = 1'b1;
        #4;
        vectors++;
        if (bif.in_ready !== 1'b0 || bif.cnt_valid !== 1'b1 || bif.cnt_data !== CNT_W'(15)) begin
            errors++;
            $display("FAIL b2b_last_bit_stall: in_ready=%b valid=%b data=%0d, required 0 1 15",
                     bif.in_ready, bif.cnt_valid, bif.cnt_data);
        end
        repeat (2) begin
            @(negedge clk);
            #4;
            vectors++;
            if (bif.in_ready !== 1'b0 || bif.cnt_data !== CNT_W'(15)) begin
                errors++;
                $display("FAIL b2b_hold: in_ready=%b data=%0d, required 0 15", bif.in_ready, bif.cnt_data);
            end
        end
        @(negedge clk);
        bif.cnt_ready = 1'b1;
        #4;
        vectors++;
        if (bif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_release: got %b, required 1", bif.in_ready);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bif.cnt_valid !== 1'b1 || bif.cnt_data !== CNT_W'(1)) begin
            errors++;
            $display("FAIL b2b_second_load: valid=%b data=%0d, required 1 1", bif.cnt_valid, bif.cnt_data);
        end
        idle(3);
    endtask

    task automatic test_flush();
        int st;
        send_frame($urandom, 1'b1, 10, -1, 1'b0, st);
        @(negedge clk);
        bif.in_valid = 1'b1;
        bif.in_bit   = 1'b1;
        bif.flush    = 1'b1;
        #4;
        vectors++;
        if (bif.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_ready: got %b, required 0", bif.in_ready);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bif.busy !== 1'b0 || bif.cnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy: busy=%b valid=%b, required 0 0", bif.busy, bif.cnt_valid);
        end
        idle(1);
        send_frame(32'hAAAAAAAA, 1'b1, FRAME_LEN, -1, 1'b1, st);
        idle(3);
    endtask

    task automatic test_overlap_toggle();
        int st;
        send_frame(32'hAAAAAAAA, 1'b1, FRAME_LEN, 4, 1'b1, st);
        idle(3);
    endtask

    task automatic test_reset_midframe();
        int st;
        @(negedge clk);
        bif.cnt_ready = 1'b0;
        send_frame(32'hAAAAAAAA, 1'b1, FRAME_LEN, -1, 1'b0, st);
        send_frame(32'hAAAAAAAA, 1'b1, 12, -1, 1'b0, st);
        @(negedge clk);
        bif.in_valid = 1'b0;
        rst          = 1'b1;
        #1;
        vectors++;
        if (bif.cnt_valid !== 1'b0 || bif.cnt_data !== '0 || bif.busy !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: valid=%b data=%0d busy=%b, required 0 0 0",
                     bif.cnt_valid, bif.cnt_data, bif.busy);
        end
        @(negedge clk);
        rst           = 1'b0;
        bif.cnt_ready = 1'b1;
        #4;
        vectors++;
        if (bif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midframe_reset_ready: got %b, required 1", bif.in_ready);
        end
        send_frame(32'h00000005, 1'b0, FRAME_LEN, -1, 1'b1, st);
        send_frame(32'hAAAAAAAA, 1'b0, FRAME_LEN, -1, 1'b1, st);
        idle(3);
    endtask

`ifdef SEQ101_MATCH_PULSE_EN
    task automatic test_match_pulse();
        int st;
        idle(2);
        pulse_cnt  = 0;
        pulse_rise = 0;
        send_frame(32'hAAAAAAAA, 1'b1, FRAME_LEN, -1, 1'b1, st);
        idle(3);
        vectors++;
        if (pulse_cnt != 15 || pulse_rise != 15) begin
            errors++;
            $display("FAIL match_pulse_count: high=%0d rises=%0d, required 15 15", pulse_cnt, pulse_rise);
        end
    endtask
`endif

    task automatic test_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_back_to_back();
        test_flush();
        test_overlap_toggle();
        test_reset_midframe();
`ifdef SEQ101_MATCH_PULSE_EN
        test_match_pulse();
`endif
        test_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
`default_nettype wire
